fir_tap_sequencer: RTL and testbench
====================================

FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 13, giving the signed sample and tap width.
REQ-002 The block SHALL have parameter COEF_WIDTH, default 13, giving the signed coefficient width.
REQ-003 The block SHALL have parameter TAPS, default 8, giving the delay-line depth (>=2).
REQ-004 The block SHALL have derived localparams TW = clog2(TAPS) and ACC_WIDTH = DATA_WIDTH+COEF_WIDTH+TW.
REQ-005 The block SHALL have port CLK, input, 1, clock.
REQ-006 The block SHALL have port RST_n, input, 1, reset (asynchronous, active-low).
REQ-007 The block SHALL have port s_valid, input, 1, input sample valid.
REQ-008 The block SHALL have port s_ready, output, 1, sequencer can accept a sample.
REQ-009 The block SHALL have port s_data, input, DATA_WIDTH signed, input sample.
REQ-010 The block SHALL have port tdl_vin, output, 1, shift enable to the tapped delay line.
REQ-011 The block SHALL have port tdl_din, output, DATA_WIDTH signed, sample presented to the delay line.
REQ-012 The block SHALL have port tap_sel, output, TW, tap index for the external tap mux.
REQ-013 The block SHALL have port tap_val, input, DATA_WIDTH signed, selected tap value, combinational from tap_sel.
REQ-014 The block SHALL have port coef_addr, output, TW, coefficient memory address.
REQ-015 The block SHALL have port coef, input, COEF_WIDTH signed, coefficient, combinational read of coef_addr.
REQ-016 The block SHALL have port m_valid, output, 1, result valid.
REQ-017 The block SHALL have port m_ready, input, 1, downstream accepts result.
REQ-018 The block SHALL have port m_data, output, ACC_WIDTH signed, filter output.
REQ-019 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-020 The block SHALL implement an FSM with the states IDLE, SHIFT, MAC and OUT.
REQ-021 In IDLE, s_ready SHALL be 1; in all other states it SHALL be 0.
REQ-022 An input handshake is s_valid&&s_ready at a rising edge; on it, tdl_din SHALL latch s_data and the FSM SHALL enter SHIFT.
REQ-023 s_data SHALL be ignored while s_ready=0.
REQ-024 In SHIFT, tdl_vin SHALL be 1 for exactly one cycle; tdl_vin SHALL be 0 in every other state.
REQ-025 After SHIFT the FSM SHALL enter MAC with index k=0.
REQ-026 In MAC, tap_sel and coef_addr SHALL both equal k.
REQ-027 In MAC, each edge SHALL update acc to (k==0 ? 0 : acc) + tap_val*coef, then increment k.
REQ-028 After the edge with k=TAPS-1, the FSM SHALL enter OUT and m_data SHALL be loaded with acc.
REQ-029 Products SHALL be full precision (DATA_WIDTH+COEF_WIDTH), sign-extended to ACC_WIDTH, with no rounding or saturation; overflow is impossible by width.
REQ-030 Latency SHALL be TAPS+2 edges from handshake to m_valid=1 (10 edges for TAPS=8).
REQ-031 In OUT, m_valid SHALL be 1, and m_data SHALL remain stable until m_valid&&m_ready.
REQ-032 On m_valid&&m_ready, the FSM SHALL go to IDLE and m_valid SHALL fall the next cycle.
REQ-033 There SHALL be no bypass, giving a maximum throughput of one sample per TAPS+3 cycles.
REQ-034 m_ready held low SHALL stall the block in OUT indefinitely, with no sample lost or accepted.
REQ-035 m_data SHALL hold its last value outside OUT.
REQ-036 tap_sel and coef_addr SHALL be 0 outside MAC.

Reset
REQ-037 Asserting RST_n low at any time, including mid-MAC, SHALL force: state IDLE, k=0, acc=0, s_ready=1, tdl_vin=0, tdl_din=0, tap_sel=0, coef_addr=0, m_valid=0, m_data=0, busy=0.
REQ-038 An in-flight result SHALL be discarded on reset; the delay line shares RST_n and clears concurrently.
REQ-039 The first handshake after reset deassertion SHALL be processed normally.

Structure
REQ-040 Package fir_pkg SHALL hold the FSM state enum typedef, the default DATA_WIDTH/COEF_WIDTH/TAPS constants and the ACC_WIDTH computation function.
REQ-041 The multiply-accumulate SHALL be a sub-module fir_mac (ports: clear-first, enable, tap_val, coef, acc), and the FSM, counter and handshakes SHALL stay in fir_tap_sequencer.

Verification
REQ-042 The bench SHALL cover: coef all 1, after reset send 5 with m_ready=1 -> m_valid at edge 10, m_data=5, tdl_vin single pulse.
REQ-043 The bench SHALL cover: coef[k]=k+1, sample stream 1,0,0,0,0,0,0,0 -> m_data sequence 1,2,3,4,5,6,7,8.
REQ-044 The bench SHALL cover: all taps -4096, all coef -4096, 8 samples -> final m_data=134217728 with no wrap.
REQ-045 The bench SHALL cover: m_ready low 20 cycles in OUT -> m_valid held, m_data stable, s_ready=0, busy=1, held s_valid not accepted.
REQ-046 The bench SHALL cover: RST_n pulsed low at MAC k=3 -> all outputs at reset values asynchronously, and the next sample 7 with coef all 1 gives m_data=7.
REQ-047 The bench SHALL cover: s_valid held high, m_ready=1 -> handshakes exactly every 11 cycles (TAPS+3).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and sizing for the FIR tap sequencer: FSM state encoding,
// default widths and the accumulator width rule.
package fir_pkg;

    localparam int DATA_WIDTH_DEF = 13;
    localparam int COEF_WIDTH_DEF = 13;
    localparam int TAPS_DEF       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MAC   = 2'd2,
        OUT   = 2'd3
    } state_e;

    // A full-precision product plus clog2(taps) guard bits can never overflow.
    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Single multiply-accumulate stage: adds tap*coef to the running sum, or
// starts a fresh sum when clear_first_i is set on the first tap.
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int COEF_WIDTH = COEF_WIDTH_DEF,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH_DEF, COEF_WIDTH_DEF, TAPS_DEF)
) (
    input  logic                         CLK,
    input  logic                         RST_n,
    input  logic                         clear_first_i,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] tap_val_i,
    input  logic signed [COEF_WIDTH-1:0] coef_i,
    output logic signed [ACC_WIDTH-1:0]  acc_o,
    output logic signed [ACC_WIDTH-1:0]  acc_nxt_o
);

    localparam int PW = DATA_WIDTH + COEF_WIDTH;

    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_d, acc_q;

    assign prod     = tap_val_i * coef_i;
    assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

    always_comb begin
        acc_d = (clear_first_i ? '0 : acc_q) + prod_ext;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_o     = acc_q;
    assign acc_nxt_o = acc_d;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR controller: accepts one sample, shifts the external
// delay line, walks TAPS taps through one MAC, then holds the result.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int COEF_WIDTH = COEF_WIDTH_DEF,
    parameter  int TAPS       = TAPS_DEF,
    localparam int TW         = $clog2(TAPS),
    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, COEF_WIDTH, TAPS)
) (
    input  logic                         CLK,
    input  logic                         RST_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    output logic                         tdl_vin,
    output logic signed [DATA_WIDTH-1:0] tdl_din,
    output logic [TW-1:0]                tap_sel,
    input  logic signed [DATA_WIDTH-1:0] tap_val,
    output logic [TW-1:0]                coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [ACC_WIDTH-1:0]  m_data,
    output logic                         busy
);

    state_e                      state_q, state_d;
    logic [TW-1:0]               k_q, k_d;
    logic signed [DATA_WIDTH-1:0] tdl_din_q, tdl_din_d;
    logic signed [ACC_WIDTH-1:0]  m_data_q, m_data_d;
    logic signed [ACC_WIDTH-1:0]  acc, acc_nxt;
    logic                         mac_en;
    logic                         last_tap;

    assign mac_en   = (state_q == MAC);
    assign last_tap = (k_q == TW'(TAPS - 1));

    fir_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .CLK           (CLK),
        .RST_n         (RST_n),
        .clear_first_i (k_q == '0),
        .en_i          (mac_en),
        .tap_val_i     (tap_val),
        .coef_i        (coef),
        .acc_o         (acc),
        .acc_nxt_o     (acc_nxt)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        tdl_din_d = tdl_din_q;
        m_data_d  = m_data_q;
        unique case (state_q)
            IDLE: begin
                if (s_valid) begin
                    tdl_din_d = s_data;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                k_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                k_d = k_q + TW'(1);
                if (last_tap) begin
                    // Capture the sum including this edge's product.
                    m_data_d = acc_nxt;
                    k_d      = '0;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            tdl_din_q <= '0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            tdl_din_q <= tdl_din_d;
            m_data_q  <= m_data_d;
        end
    end

    assign s_ready   = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign tdl_vin   = (state_q == SHIFT);
    assign m_valid   = (state_q == OUT);
    assign tap_sel   = mac_en ? k_q : '0;
    assign coef_addr = mac_en ? k_q : '0;
    assign tdl_din   = tdl_din_q;
    assign m_data    = m_data_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with a behavioural delay line and
// coefficient ROM around the DUT.
module tb_fir_tap_sequencer;

    localparam int DW   = 13;
    localparam int CW   = 13;
    localparam int TAPS = 8;
    localparam int TW   = 3;
    localparam int AW   = 29;

    logic                 CLK = 1'b0;
    logic                 RST_n;
    logic                 s_valid, s_ready;
    logic signed [DW-1:0] s_data;
    logic                 tdl_vin;
    logic signed [DW-1:0] tdl_din;
    logic [TW-1:0]        tap_sel, coef_addr;
    logic signed [DW-1:0] tap_val;
    logic signed [CW-1:0] coef;
    logic                 m_valid, m_ready;
    logic signed [AW-1:0] m_data;
    logic                 busy;

    logic signed [DW-1:0] tdl [TAPS];
    logic signed [CW-1:0] coef_mem [TAPS];

    int checks   = 0;
    int failures = 0;
    int vin_cnt  = 0;
    int cyc      = 0;
    int hs_q [$];

    always #5 CLK = ~CLK;

    fir_tap_sequencer #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .TAPS(TAPS)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .tdl_vin   (tdl_vin),
        .tdl_din   (tdl_din),
        .tap_sel   (tap_sel),
        .tap_val   (tap_val),
        .coef_addr (coef_addr),
        .coef      (coef),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .busy      (busy)
    );

    // Delay line: index 0 holds the newest sample.
    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < TAPS; i++) tdl[i] <= '0;
        end else if (tdl_vin) begin
            for (int i = TAPS - 1; i > 0; i--) tdl[i] <= tdl[i-1];
            tdl[0] <= tdl_din;
        end
    end

    assign tap_val = tdl[tap_sel];
    assign coef    = coef_mem[coef_addr];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (tdl_vin) vin_cnt <= vin_cnt + 1;
        if (RST_n && s_valid && s_ready) hs_q.push_back(cyc);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_coefs(input int mode);
        for (int i = 0; i < TAPS; i++) begin
            case (mode)
                0:       coef_mem[i] = 13'sd1;
                1:       coef_mem[i] = CW'(i + 1);
                default: coef_mem[i] = -13'sd4096;
            endcase
        end
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_n = 1'b1;
    endtask

    task automatic send_sample(input logic signed [DW-1:0] v);
        int n = 0;
        s_data  = v;
        s_valid = 1'b1;
        while (!s_ready && n < 100) begin
            @(posedge CLK); #1; n++;
        end
        if (!s_ready) check("send_timeout", 0, 1);
        else begin
            @(posedge CLK); #1;
        end
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic wait_result(input string tag, output int edges);
        edges = 0;
        while (!m_valid && edges < 100) begin
            @(posedge CLK); #1; edges++;
        end
        if (!m_valid) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_s_ready"},   s_ready,   1);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_m_valid"},   m_valid,   0);
        check({tag, "_m_data"},    m_data,    0);
        check({tag, "_tdl_vin"},   tdl_vin,   0);
        check({tag, "_tdl_din"},   tdl_din,   0);
        check({tag, "_tap_sel"},   tap_sel,   0);
        check({tag, "_coef_addr"}, coef_addr, 0);
    endtask

    initial begin
        int edges;
        int n;
        longint expv [TAPS];

        RST_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        set_coefs(0);
        #3;
        check_idle_outputs("reset");
        @(posedge CLK); #1 RST_n = 1'b1;

        // Single sample, unit coefficients: latency and one shift pulse.
        vin_cnt = 0;
        send_sample(13'sd5);
        wait_result("t1", edges);
        check("t1_latency", edges + 1, TAPS + 2);
        check("t1_m_data", m_data, 5);
        check("t1_vin_pulses", vin_cnt, 1);
        @(posedge CLK); #1;
        check("t1_m_valid_fall", m_valid, 0);

        // Impulse through ramp coefficients reads the taps back in order.
        do_reset();
        set_coefs(1);
        for (int s = 0; s < TAPS; s++) begin
            send_sample(s == 0 ? 13'sd1 : 13'sd0);
            wait_result("t2", edges);
            check($sformatf("t2_m_data_%0d", s), m_data, s + 1);
        end

        // Most negative data and coefficients: largest positive sum.
        do_reset();
        set_coefs(2);
        for (int s = 0; s < TAPS; s++) begin
            send_sample(-13'sd4096);
            wait_result("t3", edges);
            expv[s] = 64'sd16777216 * (s + 1);
            if (s == 0 || s == TAPS - 1) check($sformatf("t3_m_data_%0d", s), m_data, expv[s]);
        end
        check("t3_final", m_data, 134217728);

        // Downstream stall with a competing input held valid.
        do_reset();
        set_coefs(0);
        m_ready = 1'b0;
        send_sample(13'sd9);
        wait_result("t4", edges);
        vin_cnt = 0;
        s_valid = 1'b1;
        s_data  = 13'sd99;
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK); #1;
            check("t4_m_valid", m_valid, 1);
            check("t4_m_data", m_data, 9);
            check("t4_s_ready", s_ready, 0);
            check("t4_busy", busy, 1);
        end
        check("t4_no_accept", vin_cnt, 0);
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge CLK); #1;
        check("t4_release_m_valid", m_valid, 0);
        check("t4_release_s_ready", s_ready, 1);
        check("t4_hold_m_data", m_data, 9);

        // Asynchronous reset in the middle of the MAC walk.
        send_sample(13'sd3);
        n = 0;
        while (!(busy && tap_sel == 3'd3) && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        check("t5_reach_k3", tap_sel, 3);
        #2 RST_n = 1'b0;
        #1;
        check_idle_outputs("t5_async");
        @(posedge CLK); #1 RST_n = 1'b1;
        send_sample(13'sd7);
        wait_result("t5", edges);
        check("t5_m_data", m_data, 7);
        @(posedge CLK); #1;

        // Back-to-back throughput with input always valid.
        hs_q.delete();
        s_data  = 13'sd1;
        s_valid = 1'b1;
        repeat (48) @(posedge CLK);
        #1 s_valid = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        check("t6_hs_count_ge4", hs_q.size() >= 4, 1);
        for (int i = 1; i < 4 && i < hs_q.size(); i++)
            check($sformatf("t6_period_%0d", i), hs_q[i] - hs_q[i-1], TAPS + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
